// File: rtl/data_mem_responder_if.sv
// Core-side load/store request and response bus for data_mem_responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with byte-lane stores, extended sub-word loads
// and a programmable wait-state count.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  w_accept, w_access, w_req_err, w_mem_we;

  logic                  r_we, r_uns;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;

  logic                  r_req_ready, r_rsp_valid, r_rsp_err;
  logic [31:0]           r_rdata;

  logic [31:0]           r_mem [DEPTH];

  logic                  w_acc_we, w_acc_uns;
  logic [1:0]            w_acc_size;
  logic [ADDR_WIDTH+1:0] w_acc_addr;
  logic [31:0]           w_acc_wdata;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_lane;
  logic [31:0]           w_word, w_load, w_st_data, w_mask;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [3:0]            w_be;

  // Illegal size, misalignment, or address beyond the storage window.
  always_comb begin
    w_req_err = (bus.req_size == 2'b11)
              | ((bus.req_size == 2'b01) & bus.req_addr[0])
              | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00))
              | ((bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  end

  // Zero wait states access straight from the bus; otherwise from the captured request.
  always_comb begin
    if (r_state == IDLE) begin
      w_acc_we    = bus.req_we;
      w_acc_size  = bus.req_size;
      w_acc_uns   = bus.req_unsigned;
      w_acc_addr  = bus.req_addr[ADDR_WIDTH+1:0];
      w_acc_wdata = bus.req_wdata;
    end else begin
      w_acc_we    = r_we;
      w_acc_size  = r_size;
      w_acc_uns   = r_uns;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
    end
    w_idx  = w_acc_addr[ADDR_WIDTH+1:2];
    w_lane = w_acc_addr[1:0];
    w_word = r_mem[w_idx];
  end

  // Lane selection/extension for loads and lane replication/enables for stores.
  always_comb begin
    w_byte    = w_word[{w_lane, 3'b000} +: 8];
    w_half    = w_lane[1] ? w_word[31:16] : w_word[15:0];
    w_load    = w_word;
    w_st_data = w_acc_wdata;
    w_be      = 4'b1111;
    case (w_acc_size)
      2'b00: begin
        w_load    = w_acc_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        w_st_data = {4{w_acc_wdata[7:0]}};
        w_be      = 4'b0001 << w_lane;
      end
      2'b01: begin
        w_load    = w_acc_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        w_st_data = {2{w_acc_wdata[15:0]}};
        w_be      = w_lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_load    = w_word;
        w_st_data = w_acc_wdata;
        w_be      = 4'b1111;
      end
    endcase
    w_mask   = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    w_mem_we = w_access & w_acc_we & reset_n;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          if (w_req_err) begin
            w_state_nxt = RESP;
          end else if (WAIT_STATES == 0) begin
            w_state_nxt = RESP;
            w_access    = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
          w_access    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, captured request and registered response.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= '0;
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_size      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_uns   <= bus.req_unsigned;
        r_size  <= bus.req_size;
        r_addr  <= bus.req_addr[ADDR_WIDTH+1:0];
        r_wdata <= bus.req_wdata;
        if (w_req_err) begin
          r_rsp_err <= 1'b1;
          r_rdata   <= '0;
        end
      end
      if (w_access) begin
        r_rsp_err <= 1'b0;
        r_rdata   <= w_acc_we ? 32'h0 : w_load;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= (w_word & ~w_mask) | (w_st_data & w_mask);
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Checks three responders (1, 3 and 0 wait states) against a byte-array reference model.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [2:0]  reset_n, req_valid, req_we, req_uns, rsp_ready;
  logic [1:0]  req_size  [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [2:0]  req_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o [3];

  int          ws [3] = '{1, 3, 0};
  logic [7:0]  mdl [3][256];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WSV = (g == 0) ? 1 : (g == 1) ? 3 : 0;
    data_mem_responder_if u_if ();
    assign u_if.req_valid    = req_valid[g];
    assign u_if.req_we       = req_we[g];
    assign u_if.req_size     = req_size[g];
    assign u_if.req_unsigned = req_uns[g];
    assign u_if.req_addr     = req_addr[g];
    assign u_if.req_wdata    = req_wdata[g];
    assign u_if.rsp_ready    = rsp_ready[g];
    assign req_ready_o[g]    = u_if.req_ready;
    assign rsp_valid_o[g]    = u_if.rsp_valid;
    assign rsp_err_o[g]      = u_if.rsp_err;
    assign rsp_rdata_o[g]    = u_if.rsp_rdata;
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WSV)) u_dut (
      .clk     (clk),
      .reset_n (reset_n[g]),
      .bus     (u_if.slave)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Byte-addressed little-endian memory; stores only touch the model when legal.
  function automatic void model(input int k, input bit we, input bit [1:0] size, input bit uns,
                                input bit [31:0] addr, input bit [31:0] wdata,
                                output bit [31:0] rd, output bit err);
    int n;
    rd = 0;
    if (size == 2'd3) err = 1;
    else err = ((addr % (32'd1 << size)) != 0) || (addr >= 32'h1000);
    if (err) return;
    n = 1 << size;
    for (int i = 0; i < n; i++) begin
      if (we) mdl[k][addr + 32'(i)] = 8'(wdata >> (8 * i));
      else    rd = rd | (32'(mdl[k][addr + 32'(i)]) << (8 * i));
    end
    if (we) rd = 0;
    else if (!uns && n < 4 && rd[8 * n - 1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
  endfunction

  task automatic run_txn(input int k, input bit we, input bit [1:0] size, input bit uns,
                         input bit [31:0] addr, input bit [31:0] wdata, input int hold,
                         output logic [31:0] got);
    bit [31:0] exp;
    bit        err;
    int        t, lat;
    string     p;
    p = $sformatf("u%0d %s sz%0d @%08h", k, we ? "st" : "ld", size, addr);
    model(k, we, size, uns, addr, wdata, exp, err);
    @(negedge clk);
    req_we[k] = we; req_size[k] = size; req_uns[k] = uns;
    req_addr[k] = addr; req_wdata[k] = wdata;
    req_valid[k] = 1'b1;
    rsp_ready[k] = (hold == 0);
    t = 0;
    while (!req_ready_o[k] && t < 20) begin @(negedge clk); t++; end
    check({p, " accept"}, 32'(req_ready_o[k]), 32'd1);
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 1;
    while (!rsp_valid_o[k] && lat < 20) begin @(negedge clk); lat++; end
    check({p, " latency"}, 32'(lat), err ? 32'd1 : 32'(ws[k] + 1));
    check({p, " err"}, 32'(rsp_err_o[k]), 32'(err));
    check({p, " rdata"}, rsp_rdata_o[k], exp);
    got = rsp_rdata_o[k];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({p, " hold valid"}, 32'(rsp_valid_o[k]), 32'd1);
      check({p, " hold ready"}, 32'(req_ready_o[k]), 32'd0);
      check({p, " hold rdata"}, rsp_rdata_o[k], exp);
      check({p, " hold err"}, 32'(rsp_err_o[k]), 32'(err));
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    check({p, " done valid"}, 32'(rsp_valid_o[k]), 32'd0);
    check({p, " done ready"}, 32'(req_ready_o[k]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    bit   [31:0] exp;
    bit          err;
    int          t, acc;
    bit [1:0]    sz;
    bit [31:0]   a;

    reset_n = '0; req_valid = '0; req_we = '0; req_uns = '0; rsp_ready = '1;
    for (int k = 0; k < 3; k++) begin
      req_size[k] = 0; req_addr[k] = 0; req_wdata[k] = 0;
      for (int b = 0; b < 256; b++) mdl[k][b] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d reset req_ready", k), 32'(req_ready_o[k]), 32'd1);
      check($sformatf("u%0d reset rsp_valid", k), 32'(rsp_valid_o[k]), 32'd0);
      check($sformatf("u%0d reset rsp_err", k), 32'(rsp_err_o[k]), 32'd0);
      check($sformatf("u%0d reset rdata", k), rsp_rdata_o[k], 32'd0);
    end
    reset_n = '1;

    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 64; w++) run_txn(k, 1, 2'd2, 0, 32'(w * 4), $urandom, 0, got);

    // Word/byte/halfword sequence on the single-wait-state unit.
    run_txn(0, 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 0, got);
    run_txn(0, 0, 2'd2, 0, 32'h10, 0, 0, got);
    check("seq ld word", got, 32'hDEAD_BEEF);
    run_txn(0, 1, 2'd0, 0, 32'h11, 32'h0000_0080, 0, got);
    run_txn(0, 0, 2'd0, 0, 32'h11, 0, 0, got);
    check("seq ld sbyte", got, 32'hFFFF_FF80);
    run_txn(0, 0, 2'd1, 1, 32'h10, 0, 0, got);
    check("seq ld uhalf", got, 32'h0000_80EF);
    run_txn(0, 0, 2'd2, 1, 32'h10, 0, 0, got);
    check("seq ld word2", got, 32'hDEAD_80EF);

    // Error cases, including an erroneous store, leave memory untouched.
    run_txn(0, 0, 2'd2, 0, 32'h12, 0, 0, got);
    run_txn(0, 0, 2'd1, 0, 32'h13, 0, 0, got);
    run_txn(0, 0, 2'd3, 0, 32'h10, 0, 0, got);
    run_txn(0, 0, 2'd2, 0, 32'h1000, 0, 0, got);
    run_txn(0, 1, 2'd2, 0, 32'h12, 32'h5555_5555, 0, got);
    run_txn(0, 0, 2'd2, 0, 32'h10, 0, 0, got);
    check("err mem unchanged", got, 32'hDEAD_80EF);

    run_txn(0, 0, 2'd2, 0, 32'h10, 0, 5, got);

    // Reset in the second wait cycle discards a pending store.
    run_txn(1, 1, 2'd2, 0, 32'h20, 32'h0, 0, got);
    @(negedge clk);
    req_we[1] = 1; req_size[1] = 2'd2; req_uns[1] = 0;
    req_addr[1] = 32'h20; req_wdata[1] = 32'h1234_5678; req_valid[1] = 1;
    t = 0;
    while (!req_ready_o[1] && t < 20) begin @(negedge clk); t++; end
    check("abort accept", 32'(req_ready_o[1]), 32'd1);
    @(negedge clk);
    req_valid[1] = 0;
    check("abort wait1 valid", 32'(rsp_valid_o[1]), 32'd0);
    @(negedge clk);
    reset_n[1] = 0;
    @(negedge clk);
    reset_n[1] = 1;
    check("abort rsp_valid", 32'(rsp_valid_o[1]), 32'd0);
    check("abort req_ready", 32'(req_ready_o[1]), 32'd1);
    check("abort rsp_err", 32'(rsp_err_o[1]), 32'd0);
    check("abort rdata", rsp_rdata_o[1], 32'd0);
    run_txn(1, 0, 2'd2, 0, 32'h20, 0, 0, got);
    check("abort mem", got, 32'h0);

    // Zero-wait-state unit with req_valid held: one accept every two cycles.
    model(2, 0, 2'd2, 0, 32'h30, 0, exp, err);
    @(negedge clk);
    req_we[2] = 0; req_size[2] = 2'd2; req_uns[2] = 0; req_addr[2] = 32'h30;
    req_valid[2] = 1; rsp_ready[2] = 1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b ready c%0d", i), 32'(req_ready_o[2]), 32'((i % 2) == 0));
      check($sformatf("b2b valid c%0d", i), 32'(rsp_valid_o[2]), 32'((i % 2) == 1));
      if (rsp_valid_o[2]) check($sformatf("b2b rdata c%0d", i), rsp_rdata_o[2], exp);
      if (req_ready_o[2]) acc++;
      if (i == 7) req_valid[2] = 0;
      @(negedge clk);
    end
    check("b2b accepts", 32'(acc), 32'd4);

    // Randomised mix across all three units.
    repeat (300) begin
      int k;
      int r;
      k  = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      if (r == 0) a = $urandom | 32'h1000;
      else begin
        a = 32'($urandom_range(0, 255));
        if (r < 8 && sz != 2'd3) a = a & ~((32'd1 << sz) - 1);
      end
      run_txn(k, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
              $urandom_range(0, 2), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the word-address width; storage is 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1, range 0..7, SHALL set the access latency in cycles.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 Port req_valid  input  1  SHALL indicate a load/store request from the core.
REQ-006 Port req_ready  output  1  SHALL indicate the block can accept a request.
REQ-007 Port req_we  input  1  SHALL select store (1) or load (0).
REQ-008 Port req_size  input  2  SHALL give the access size: 00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-009 Port req_unsigned  input  1  SHALL select zero-extension (1) or sign-extension (0) for sub-word loads.
REQ-010 Port req_addr  input  32  SHALL be the byte address.
REQ-011 Port req_wdata  input  32  SHALL carry store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-012 Port rsp_valid  output  1  SHALL indicate a completed response.
REQ-013 Port rsp_ready  input  1  SHALL indicate the core accepts the response.
REQ-014 Port rsp_rdata  output  32  SHALL carry extended load data; 0 for stores and errors.
REQ-015 Port rsp_err  output  1  SHALL flag an illegal, misaligned or out-of-range request.

Function
REQ-016 FSM states SHALL be IDLE, WAIT and RESP, with exactly one request outstanding at a time.
REQ-017 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-018 Acceptance SHALL occur on a rising edge where req_valid=1 and req_ready=1; all request fields are captured on that edge.
REQ-019 Error conditions: req_size=11; halfword with addr[0]=1; word with addr[1:0]!=00; or any bit of addr[31:ADDR_WIDTH+2] set.
REQ-020 An erroneous request SHALL go IDLE->RESP directly, with rsp_err=1 and rsp_rdata=0; memory is unchanged.
REQ-021 A legal request SHALL go IDLE->RESP when WAIT_STATES=0, otherwise IDLE->WAIT with the wait counter loaded to WAIT_STATES-1.
REQ-022 In WAIT the counter SHALL decrement each cycle; on the cycle it equals 0 the access is performed and the state moves to RESP.
REQ-023 Latency: rsp_valid SHALL first be 1 in the cycle that is WAIT_STATES+1 cycles after the accept edge.
REQ-024 A store SHALL update only the addressed byte lanes (byte: lane addr[1:0]; halfword: lanes addr[1]*2 and +1; word: all lanes) of word addr[ADDR_WIDTH+1:2], on the edge entering RESP.
REQ-025 A load SHALL select the addressed lane(s), sign- or zero-extend to 32 bits per req_unsigned, and register the result on the edge entering RESP.
REQ-026 Word loads SHALL ignore req_unsigned.
REQ-027 In RESP, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1, which returns the FSM to IDLE.
REQ-028 req_valid changes during WAIT or RESP SHALL be ignored; the request is not captured until the FSM is back in IDLE.
REQ-029 A new request SHALL NOT be accepted on the same edge that completes a response; the minimum request period is WAIT_STATES+2 cycles.
REQ-030 A load from a word stored by the immediately preceding request SHALL return the new data.

Reset
REQ-031 While reset_n=0 at a rising edge: FSM SHALL enter IDLE, the counter SHALL clear, and rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready SHALL be 1 in the following cycle.
REQ-032 A store pending in WAIT when reset is applied SHALL be discarded, leaving memory unchanged.
REQ-033 Memory contents SHALL NOT be initialised by reset.

Verification
REQ-034 WAIT_STATES=1, rsp_ready=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_rdata=0xDEADBEEF and rsp_err=0; rsp_valid rises 2 cycles after each accept.
REQ-035 After REQ-034: store byte 0x80 @0x11, then load signed byte @0x11 -> 0xFFFFFF80; load unsigned halfword @0x10 -> 0x000080EF; load word -> 0xDEAD80EF.
REQ-036 Load word @0x12, load halfword @0x13, req_size=11, and (ADDR_WIDTH=10) load @0x1000 -> each gives rsp_err=1 and rsp_rdata=0 one cycle after accept; memory is unchanged.
REQ-037 Hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; accept occurs only after the handshake.
REQ-038 WAIT_STATES=3: store word 0x12345678 @0x20, with reset_n=0 asserted in the second WAIT cycle -> next cycle in IDLE with rsp_valid=0; a load @0x20 then does not return 0x12345678 (pre-initialise the word to 0 first).
REQ-039 WAIT_STATES=0: back-to-back loads with req_valid held at 1 -> one accept every 2 cycles, and rsp_valid is 1 in the cycle after each accept.
